// File: rtl/elevator_call_scheduler.sv
// Purpose: latch four floor calls and pick the next destination with a SCAN policy,
//          hand it to the motion controller, then wait for arrival and hold the door.
// Latency: call at edge n -> SELECT after n+1 -> cmd_valid after n+2; cmd held until cmd_ready.
module elevator_call_scheduler #(
   parameter int DOOR_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] call_n,
   input  logic [3:0] sen,
   input  logic       cmd_ready,
   input  logic       arrived,
   output logic       cmd_valid,
   output logic [1:0] cmd_dest,
   output logic       cmd_up,
   output logic [3:0] pending,
   output logic [1:0] cur_floor,
   output logic       door_hold,
   output logic       fault,
   output logic [2:0] state_code
);

   localparam int DW = $clog2(DOOR_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES);
   localparam logic [DW-1:0] DOOR_ONE  = DW'(1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      ISSUE  = 3'd2,
      WAIT   = 3'd3,
      HOLD   = 3'd4,
      FAULT  = 3'd5
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            dir_up;
   logic [DW-1:0]   door_cnt;
   logic [WW-1:0]   wdog;

   logic [3:0]      above;
   logic [3:0]      below;
   logic [1:0]      lo_above;
   logic [1:0]      hi_below;
   logic            sen_onehot;
   logic [1:0]      sen_idx;

   logic [3:0]      clr_mask;
   logic            door_load;
   logic            door_dec;
   logic            wdog_clr;
   logic            wdog_inc;
   logic            sel_load;
   logic [1:0]      sel_dest;
   logic            sel_up;
   logic            arrive;

   // Split pending calls around the current floor and find the nearest call each way.
   always_comb begin
      above    = '0;
      below    = '0;
      lo_above = 2'd0;
      hi_below = 2'd0;
      for (int i = 0; i < 4; i++) begin
         above[i] = pending[i] && (i > int'(cur_floor));
         below[i] = pending[i] && (i < int'(cur_floor));
      end
      for (int i = 3; i >= 0; i--) begin
         if (above[i]) lo_above = 2'(i);
      end
      for (int i = 0; i < 4; i++) begin
         if (below[i]) hi_below = 2'(i);
      end
   end

   // Decode the floor sensors; ambiguous or empty readings leave cur_floor alone.
   always_comb begin
      sen_onehot = $onehot(sen);
      sen_idx    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (sen[i]) sen_idx = 2'(i);
      end
   end

   // Next-state and datapath control for the scheduler FSM.
   always_comb begin
      state_next = state;
      clr_mask   = '0;
      door_load  = 1'b0;
      door_dec   = 1'b0;
      wdog_clr   = 1'b0;
      wdog_inc   = 1'b0;
      sel_load   = 1'b0;
      sel_dest   = cmd_dest;
      sel_up     = cmd_up;
      arrive     = 1'b0;
      case (state)
         IDLE: begin
            if (pending[cur_floor] && sen[cur_floor]) begin
               clr_mask[cur_floor] = 1'b1;
               door_load           = 1'b1;
               state_next          = HOLD;
            end else if (|pending) begin
               state_next = SELECT;
            end
         end
         SELECT: begin
            state_next = IDLE;
            if (dir_up) begin
               if (|above) begin
                  sel_load = 1'b1; sel_dest = lo_above; sel_up = 1'b1;
               end else if (|below) begin
                  sel_load = 1'b1; sel_dest = hi_below; sel_up = 1'b0;
               end
            end else begin
               if (|below) begin
                  sel_load = 1'b1; sel_dest = hi_below; sel_up = 1'b0;
               end else if (|above) begin
                  sel_load = 1'b1; sel_dest = lo_above; sel_up = 1'b1;
               end
            end
            if (sel_load) state_next = ISSUE;
         end
         ISSUE: begin
            if (cmd_ready) begin
               wdog_clr   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (arrived) begin
               clr_mask[cmd_dest] = 1'b1;
               arrive             = 1'b1;
               door_load          = 1'b1;
               state_next         = HOLD;
            end else begin
               wdog_inc = 1'b1;
               if (wdog == WDOG_LAST) state_next = FAULT;
            end
         end
         HOLD: begin
            if (!call_n[cur_floor]) begin
               clr_mask[cur_floor] = 1'b1;
               door_load           = 1'b1;
            end else if (door_cnt <= DOOR_ONE) begin
               state_next = IDLE;
            end else begin
               door_dec = 1'b1;
            end
         end
         FAULT: state_next = FAULT;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Call latch, floor tracking, command registers and the two counters.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pending   <= '0;
         cur_floor <= 2'd0;
         cmd_dest  <= 2'd0;
         cmd_up    <= 1'b1;
         dir_up    <= 1'b1;
         door_cnt  <= '0;
         wdog      <= '0;
      end else begin
         // A clear from the FSM beats a button press on the same bit.
         pending <= (pending | ~call_n) & ~clr_mask;
         if (arrive)          cur_floor <= cmd_dest;
         else if (sen_onehot) cur_floor <= sen_idx;
         if (sel_load) begin
            cmd_dest <= sel_dest;
            cmd_up   <= sel_up;
            dir_up   <= sel_up;
         end
         if (door_load)     door_cnt <= DOOR_LOAD;
         else if (door_dec) door_cnt <= door_cnt - DOOR_ONE;
         if (wdog_clr)      wdog <= '0;
         else if (wdog_inc) wdog <= wdog + WW'(1);
      end
   end

   assign cmd_valid  = (state == ISSUE);
   assign door_hold  = (state == HOLD);
   assign fault      = (state == FAULT);
   assign state_code = state;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: table of directed vectors plus hand sequences
// for door re-press, arrival timeout and reset during WAIT.
// Outputs are sampled 1 time unit after each rising edge.
module tb_elevator_call_scheduler;

   localparam int DC = 8;
   localparam int TO = 1024;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] call_n = 4'hF;
   logic [3:0] sen = 4'b0001;
   logic       cmd_ready = 1'b0;
   logic       arrived = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd_dest;
   logic       cmd_up;
   logic [3:0] pending;
   logic [1:0] cur_floor;
   logic       door_hold;
   logic       fault;
   logic [2:0] state_code;

   int n_cmp = 0;
   int n_bad = 0;

   elevator_call_scheduler #(.DOOR_CYCLES(DC), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .call_n(call_n), .sen(sen),
      .cmd_ready(cmd_ready), .arrived(arrived), .cmd_valid(cmd_valid),
      .cmd_dest(cmd_dest), .cmd_up(cmd_up), .pending(pending),
      .cur_floor(cur_floor), .door_hold(door_hold), .fault(fault),
      .state_code(state_code)
   );

   always #5 clock = ~clock;

   // Observed outputs packed as {valid, dest, up, pending, cur_floor, door_hold, fault, state}.
   logic [14:0] obs;
   assign obs = {cmd_valid, cmd_dest, cmd_up, pending, cur_floor, door_hold, fault, state_code};

   localparam logic [14:0] RESET_OBS = {1'b0, 2'd0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'd0};

   typedef struct {
      int         n;
      logic       rst;
      logic [3:0] call;
      logic [3:0] s;
      logic       rdy;
      logic       arr;
      logic [14:0] exp;
   } vec_t;

   vec_t vt[$];

   task automatic add(input int n, input logic rst, input logic [3:0] call, input logic [3:0] s,
                      input logic rdy, input logic arr, input logic v, input logic [1:0] d,
                      input logic u, input logic [3:0] p, input logic [1:0] cf, input logic dh,
                      input logic f, input logic [2:0] st);
      vec_t e;
      e.n = n; e.rst = rst; e.call = call; e.s = s; e.rdy = rdy; e.arr = arr;
      e.exp = {v, d, u, p, cf, dh, f, st};
      vt.push_back(e);
   endtask

   task automatic step(input logic rst, input logic [3:0] call, input logic [3:0] s,
                       input logic rdy, input logic arr);
      @(negedge clock);
      reset = rst; call_n = call; sen = s; cmd_ready = rdy; arrived = arr;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int wait_bad;
      //   n rst call     sen      rdy arr  v  d    u  pend     cf   dh f  st
      add(2, 0, 4'b0000, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b0000, 2'd0, 0, 0, 3'd0);
      add(1, 1, 4'b0000, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b1111, 2'd0, 0, 0, 3'd0);
      add(1, 1, 4'b0000, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b1110, 2'd0, 1, 0, 3'd4);
      add(1, 0, 4'b1111, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b0000, 2'd0, 0, 0, 3'd0);
      add(1, 1, 4'b1111, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b0000, 2'd0, 0, 0, 3'd0);
      add(1, 1, 4'b1011, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b0100, 2'd0, 0, 0, 3'd0);
      add(1, 1, 4'b1111, 4'b0001, 0, 0,   0, 2'd0, 1, 4'b0100, 2'd0, 0, 0, 3'd1);
      add(1, 1, 4'b1111, 4'b0001, 0, 0,   1, 2'd2, 1, 4'b0100, 2'd0, 0, 0, 3'd2);
      add(5, 1, 4'b1111, 4'b0001, 0, 0,   1, 2'd2, 1, 4'b0100, 2'd0, 0, 0, 3'd2);
      add(1, 1, 4'b1111, 4'b0001, 1, 0,   0, 2'd2, 1, 4'b0100, 2'd0, 0, 0, 3'd3);
      add(3, 1, 4'b1111, 4'b0000, 0, 0,   0, 2'd2, 1, 4'b0100, 2'd0, 0, 0, 3'd3);
      add(1, 1, 4'b1111, 4'b0100, 0, 1,   0, 2'd2, 1, 4'b0000, 2'd2, 1, 0, 3'd4);
      add(DC-1, 1, 4'b1111, 4'b0100, 0, 0, 0, 2'd2, 1, 4'b0000, 2'd2, 1, 0, 3'd4);
      add(2, 1, 4'b1111, 4'b0100, 0, 1,   0, 2'd2, 1, 4'b0000, 2'd2, 0, 0, 3'd0);
      add(1, 1, 4'b1111, 4'b0010, 0, 0,   0, 2'd2, 1, 4'b0000, 2'd1, 0, 0, 3'd0);
      add(1, 1, 4'b0110, 4'b0010, 0, 0,   0, 2'd2, 1, 4'b1001, 2'd1, 0, 0, 3'd0);
      add(1, 1, 4'b1111, 4'b0010, 0, 0,   0, 2'd2, 1, 4'b1001, 2'd1, 0, 0, 3'd1);
      add(1, 1, 4'b1111, 4'b0010, 0, 0,   1, 2'd3, 1, 4'b1001, 2'd1, 0, 0, 3'd2);
      add(1, 1, 4'b1111, 4'b0000, 1, 0,   0, 2'd3, 1, 4'b1001, 2'd1, 0, 0, 3'd3);
      add(1, 1, 4'b1111, 4'b1000, 0, 1,   0, 2'd3, 1, 4'b0001, 2'd3, 1, 0, 3'd4);
      add(DC-1, 1, 4'b1111, 4'b1000, 0, 0, 0, 2'd3, 1, 4'b0001, 2'd3, 1, 0, 3'd4);
      add(1, 1, 4'b1111, 4'b1000, 0, 0,   0, 2'd3, 1, 4'b0001, 2'd3, 0, 0, 3'd0);
      add(1, 1, 4'b1111, 4'b1000, 0, 0,   0, 2'd3, 1, 4'b0001, 2'd3, 0, 0, 3'd1);
      add(1, 1, 4'b1111, 4'b1000, 0, 0,   1, 2'd0, 0, 4'b0001, 2'd3, 0, 0, 3'd2);
      add(1, 1, 4'b1111, 4'b0000, 1, 0,   0, 2'd0, 0, 4'b0001, 2'd3, 0, 0, 3'd3);
      add(1, 1, 4'b1111, 4'b0001, 0, 1,   0, 2'd0, 0, 4'b0000, 2'd0, 1, 0, 3'd4);
      add(DC-1, 1, 4'b1111, 4'b0001, 0, 0, 0, 2'd0, 0, 4'b0000, 2'd0, 1, 0, 3'd4);
      add(1, 1, 4'b1111, 4'b0001, 0, 0,   0, 2'd0, 0, 4'b0000, 2'd0, 0, 0, 3'd0);

      foreach (vt[i]) begin
         for (int r = 0; r < vt[i].n; r++) begin
            step(vt[i].rst, vt[i].call, vt[i].s, vt[i].rdy, vt[i].arr);
            chk($sformatf("vec%0d.%0d", i, r), obs, vt[i].exp);
         end
      end

      // Same-floor call in IDLE opens the door without a command; re-press restarts the hold.
      step(1, 4'b1111, 4'b0100, 0, 0);
      chk("same_floor_cf", obs, {1'b0, 2'd0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 3'd0});
      step(1, 4'b1011, 4'b0100, 0, 0);
      chk("same_floor_latch", obs, {1'b0, 2'd0, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0, 3'd0});
      step(1, 4'b1111, 4'b0100, 0, 0);
      chk("same_floor_hold", obs, {1'b0, 2'd0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 3'd4});
      repeat (3) step(1, 4'b1111, 4'b0100, 0, 0);
      step(1, 4'b1011, 4'b0100, 0, 0);
      chk("repress_reload", obs, {1'b0, 2'd0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 3'd4});
      for (int k = 1; k < DC; k++) begin
         step(1, 4'b1111, 4'b0100, 0, 0);
         chk($sformatf("repress_hold%0d", k), obs,
             {1'b0, 2'd0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 3'd4});
      end
      step(1, 4'b1111, 4'b0100, 0, 0);
      chk("repress_release", obs, {1'b0, 2'd0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 3'd0});

      // Accepted command with no arrival runs into the watchdog.
      step(1, 4'b1110, 4'b0100, 0, 0);
      step(1, 4'b1111, 4'b0100, 0, 0);
      step(1, 4'b1111, 4'b0100, 0, 0);
      chk("to_issue", obs, {1'b1, 2'd0, 1'b0, 4'b0001, 2'd2, 1'b0, 1'b0, 3'd2});
      step(1, 4'b1111, 4'b0100, 1, 0);
      chk("to_wait", obs, {1'b0, 2'd0, 1'b0, 4'b0001, 2'd2, 1'b0, 1'b0, 3'd3});
      wait_bad = 0;
      for (int k = 1; k < TO; k++) begin
         step(1, 4'b1111, 4'b0100, 0, 0);
         if (state_code !== 3'd3) wait_bad++;
      end
      n_cmp++;
      if (wait_bad != 0) begin
         n_bad++;
         $display("FAIL wait_span: %0d cycles left WAIT early, required 0", wait_bad);
      end
      step(1, 4'b1111, 4'b0100, 0, 0);
      chk("timeout_fault", obs, {1'b0, 2'd0, 1'b0, 4'b0001, 2'd2, 1'b0, 1'b1, 3'd5});
      step(1, 4'b0111, 4'b0100, 0, 0);
      chk("fault_latch", obs, {1'b0, 2'd0, 1'b0, 4'b1001, 2'd2, 1'b0, 1'b1, 3'd5});
      step(1, 4'b1111, 4'b0100, 0, 1);
      chk("fault_late_arrival", obs, {1'b0, 2'd0, 1'b0, 4'b1001, 2'd2, 1'b0, 1'b1, 3'd5});
      repeat (3) step(1, 4'b1111, 4'b0100, 1, 0);
      chk("fault_sticky", obs, {1'b0, 2'd0, 1'b0, 4'b1001, 2'd2, 1'b0, 1'b1, 3'd5});
      step(0, 4'b1111, 4'b0100, 0, 0);
      chk("fault_reset", obs, RESET_OBS);

      // Reset while waiting for arrival with calls outstanding.
      step(1, 4'b0101, 4'b0100, 0, 0);
      chk("w_latch", obs, {1'b0, 2'd0, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b0, 3'd0});
      step(1, 4'b1111, 4'b0100, 0, 0);
      step(1, 4'b1111, 4'b0100, 0, 0);
      chk("w_issue", obs, {1'b1, 2'd3, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b0, 3'd2});
      step(1, 4'b1111, 4'b0000, 1, 0);
      chk("w_wait", obs, {1'b0, 2'd3, 1'b1, 4'b1010, 2'd2, 1'b0, 1'b0, 3'd3});
      step(0, 4'b1111, 4'b0000, 0, 0);
      chk("w_reset", obs, RESET_OBS);
      for (int k = 0; k < 4; k++) begin
         step(1, 4'b1111, 4'b0000, 0, 0);
         chk($sformatf("post_reset_idle%0d", k), obs, RESET_OBS);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
